// File: rtl/pipe_pkg.sv
// +--------------------------------------------------------------------+
// | pipe_pkg : control-bundle bit map and forwarding-select encodings  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int ALU_OP_LO  = 5;
  localparam int ALU_OP_HI  = 7;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_fwd_stage_if.sv
// +--------------------------------------------------------------------+
// | id_ex_fwd_stage_if : ID inputs, forwarding sources and EX outputs  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface id_ex_fwd_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
);

  logic              mem_stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_addr_i;
  logic [REG_AW-1:0] id_rs2_addr_i;
  logic              id_uses_rs1_i;
  logic              id_uses_rs2_i;
  logic [DATA_W-1:0] id_rs1_data_i;
  logic [DATA_W-1:0] id_rs2_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rd_addr_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              exmem_reg_write_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic              memwb_reg_write_i;
  logic [REG_AW-1:0] memwb_rd_i;

  logic              ex_valid_o;
  logic [REG_AW-1:0] ex_rs1_addr_o;
  logic [REG_AW-1:0] ex_rs2_addr_o;
  logic [DATA_W-1:0] ex_rs1_data_o;
  logic [DATA_W-1:0] ex_rs2_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_AW-1:0] ex_rd_addr_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [1:0]        fwd_a_sel_o;
  logic [1:0]        fwd_b_sel_o;
  logic              hazard_stall_o;

  modport master (
    output mem_stall_i, flush_i, id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rd_addr_i, id_ctrl_i, exmem_reg_write_i, exmem_rd_i,
           memwb_reg_write_i, memwb_rd_i,
    input  ex_valid_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_ctrl_o, fwd_a_sel_o,
           fwd_b_sel_o, hazard_stall_o
  );

  modport slave (
    input  mem_stall_i, flush_i, id_valid_i, id_rs1_addr_i, id_rs2_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_rd_addr_i, id_ctrl_i, exmem_reg_write_i, exmem_rd_i,
           memwb_reg_write_i, memwb_rd_i,
    output ex_valid_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rs1_data_o,
           ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_ctrl_o, fwd_a_sel_o,
           fwd_b_sel_o, hazard_stall_o
  );

endinterface

`default_nettype wire

// File: rtl/id_ex_fwd_stage_fwd_sel_unit.sv
// +--------------------------------------------------------------------+
// | fwd_sel_unit : operand-mux select for one EX source operand        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fwd_sel_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              uses_i,
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output logic [1:0]        sel_o
);

  logic hit_mem;
  logic hit_wb;

  // x0 is hard-wired zero, so a write to it never provides a forwarded value
  assign hit_mem = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_addr_i);
  assign hit_wb  = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == src_addr_i);

  always_comb begin
    sel_o = FWD_REG;
    if (ex_valid_i && uses_i) begin
      if (hit_mem) begin
        sel_o = FWD_MEM;
      end else if (hit_wb) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_fwd_stage.sv
// +--------------------------------------------------------------------+
// | id_ex_fwd_stage : ID/EX register, forwarding selects, load-use stall|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module id_ex_fwd_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  id_ex_fwd_stage_if.slave bus
);

  logic              valid_q,    valid_d;
  logic              uses1_q,    uses1_d;
  logic              uses2_q,    uses2_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;

  logic hazard;
  logic bubble;

  // A load in EX whose rd is read by the instruction in ID cannot be forwarded yet
  assign hazard = bus.id_valid_i && valid_q && ctrl_q[MEM_READ] && !bus.flush_i
                  && (rd_addr_q != '0)
                  && ((bus.id_uses_rs1_i && (bus.id_rs1_addr_i == rd_addr_q)) ||
                      (bus.id_uses_rs2_i && (bus.id_rs2_addr_i == rd_addr_q)));

  assign bubble = bus.flush_i || hazard;

  always_comb begin
    valid_d    = bubble ? 1'b0 : bus.id_valid_i;
    uses1_d    = bubble ? 1'b0 : bus.id_uses_rs1_i;
    uses2_d    = bubble ? 1'b0 : bus.id_uses_rs2_i;
    rs1_addr_d = bubble ? '0   : bus.id_rs1_addr_i;
    rs2_addr_d = bubble ? '0   : bus.id_rs2_addr_i;
    rd_addr_d  = bubble ? '0   : bus.id_rd_addr_i;
    rs1_data_d = bubble ? '0   : bus.id_rs1_data_i;
    rs2_data_d = bubble ? '0   : bus.id_rs2_data_i;
    imm_d      = bubble ? '0   : bus.id_imm_i;
    ctrl_d     = (bubble || !bus.id_valid_i) ? '0 : bus.id_ctrl_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      uses1_q    <= 1'b0;
      uses2_q    <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
    end else if (!bus.mem_stall_i) begin
      valid_q    <= valid_d;
      uses1_q    <= uses1_d;
      uses2_q    <= uses2_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
    end
  end

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_valid_i (valid_q),
    .uses_i     (uses1_q),
    .src_addr_i (rs1_addr_q),
    .exmem_we_i (bus.exmem_reg_write_i),
    .exmem_rd_i (bus.exmem_rd_i),
    .memwb_we_i (bus.memwb_reg_write_i),
    .memwb_rd_i (bus.memwb_rd_i),
    .sel_o      (bus.fwd_a_sel_o)
  );

  fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_valid_i (valid_q),
    .uses_i     (uses2_q),
    .src_addr_i (rs2_addr_q),
    .exmem_we_i (bus.exmem_reg_write_i),
    .exmem_rd_i (bus.exmem_rd_i),
    .memwb_we_i (bus.memwb_reg_write_i),
    .memwb_rd_i (bus.memwb_rd_i),
    .sel_o      (bus.fwd_b_sel_o)
  );

  assign bus.ex_valid_o     = valid_q;
  assign bus.ex_rs1_addr_o  = rs1_addr_q;
  assign bus.ex_rs2_addr_o  = rs2_addr_q;
  assign bus.ex_rs1_data_o  = rs1_data_q;
  assign bus.ex_rs2_data_o  = rs2_data_q;
  assign bus.ex_imm_o       = imm_q;
  assign bus.ex_rd_addr_o   = rd_addr_q;
  assign bus.ex_ctrl_o      = ctrl_q;
  assign bus.hazard_stall_o = hazard;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
// +--------------------------------------------------------------------+
// | tb_id_ex_fwd_stage : directed vectors plus randomized model check  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_fwd_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  id_ex_fwd_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(8)) bus ();

  id_ex_fwd_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of what EX currently holds
  logic        m_valid, m_u1, m_u2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [7:0]  m_ctrl;

  typedef struct {
    logic [4:0] rs1;  logic u1;
    logic [4:0] rs2;  logic u2;
    logic       exw;  logic [4:0] exrd;
    logic       wbw;  logic [4:0] wbrd;
    logic [1:0] ea;   logic [1:0] eb;
  } fwd_vec_t;

  fwd_vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    logic dep1, dep2;
    dep1 = bus.id_uses_rs1_i && (bus.id_rs1_addr_i == m_rd);
    dep2 = bus.id_uses_rs2_i && (bus.id_rs2_addr_i == m_rd);
    return bus.id_valid_i && m_valid && m_ctrl[1] && !bus.flush_i && (m_rd != 0) && (dep1 || dep2);
  endfunction

  function automatic logic [1:0] m_sel(input logic u, input logic [4:0] a);
    if (!m_valid || !u) return 2'b00;
    if (bus.exmem_reg_write_i && bus.exmem_rd_i != 0 && bus.exmem_rd_i == a) return 2'b10;
    if (bus.memwb_reg_write_i && bus.memwb_rd_i != 0 && bus.memwb_rd_i == a) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_u1 = 0; m_u2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_ctrl = 0;
  endtask

  task automatic model_edge();
    logic hz;
    hz = m_hazard();
    if (!rst_n) model_clear();
    else if (bus.mem_stall_i) begin end
    else if (bus.flush_i || hz) model_clear();
    else begin
      m_valid = bus.id_valid_i;
      m_u1 = bus.id_uses_rs1_i;     m_u2 = bus.id_uses_rs2_i;
      m_rs1 = bus.id_rs1_addr_i;    m_rs2 = bus.id_rs2_addr_i;
      m_rd = bus.id_rd_addr_i;      m_imm = bus.id_imm_i;
      m_d1 = bus.id_rs1_data_i;     m_d2 = bus.id_rs2_data_i;
      m_ctrl = bus.id_valid_i ? bus.id_ctrl_i : 8'h00;
    end
  endtask

  // Called just after a falling edge with the inputs for this cycle already driven
  task automatic cycle(input bit pre_chk);
    #1;
    if (pre_chk) begin
      chk("hazard", 32'(bus.hazard_stall_o), 32'(m_hazard()));
      chk("fwd_a", 32'(bus.fwd_a_sel_o), 32'(m_sel(m_u1, m_rs1)));
      chk("fwd_b", 32'(bus.fwd_b_sel_o), 32'(m_sel(m_u2, m_rs2)));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("ex_valid", 32'(bus.ex_valid_o), 32'(m_valid));
    chk("ex_ctrl", 32'(bus.ex_ctrl_o), 32'(m_ctrl));
    chk("ex_rd", 32'(bus.ex_rd_addr_o), 32'(m_rd));
    chk("ex_rs1_addr", 32'(bus.ex_rs1_addr_o), 32'(m_rs1));
    chk("ex_rs2_addr", 32'(bus.ex_rs2_addr_o), 32'(m_rs2));
    chk("ex_rs1_data", bus.ex_rs1_data_o, m_d1);
    chk("ex_rs2_data", bus.ex_rs2_data_o, m_d2);
    chk("ex_imm", bus.ex_imm_o, m_imm);
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [31:0] d1,
                        input logic [4:0] rd, input logic [7:0] ctrl);
    bus.id_valid_i = v;
    bus.id_rs1_addr_i = rs1;  bus.id_uses_rs1_i = u1;
    bus.id_rs2_addr_i = rs2;  bus.id_uses_rs2_i = u2;
    bus.id_rs1_data_i = d1;   bus.id_rs2_data_i = ~d1;
    bus.id_imm_i = {d1[15:0], d1[31:16]};
    bus.id_rd_addr_i = rd;    bus.id_ctrl_i = ctrl;
  endtask

  task automatic set_fwd(input logic exw, input logic [4:0] exrd,
                         input logic wbw, input logic [4:0] wbrd);
    bus.exmem_reg_write_i = exw;  bus.exmem_rd_i = exrd;
    bus.memwb_reg_write_i = wbw;  bus.memwb_rd_i = wbrd;
  endtask

  task automatic rand_id();
    set_id(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), $urandom, 5'($urandom_range(0, 7)), 8'($urandom));
    bus.id_rs2_data_i = $urandom;
    bus.id_imm_i = $urandom;
    set_fwd(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    rst_n = 1'b0;
    bus.mem_stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0);

    //          rs1 u1 rs2 u2 exw exrd wbw wbrd ea     eb
    vecs[0] = '{5'd5, 1, 5'd9, 1, 1, 5'd5, 1, 5'd5, 2'b10, 2'b00};
    vecs[1] = '{5'd5, 1, 5'd9, 1, 0, 5'd5, 1, 5'd5, 2'b01, 2'b00};
    vecs[2] = '{5'd5, 1, 5'd0, 1, 1, 5'd0, 1, 5'd0, 2'b00, 2'b00};
    vecs[3] = '{5'd3, 0, 5'd3, 0, 1, 5'd3, 1, 5'd3, 2'b00, 2'b00};
    vecs[4] = '{5'd4, 1, 5'd4, 1, 0, 5'd4, 1, 5'd4, 2'b01, 2'b01};
    vecs[5] = '{5'd6, 1, 5'd8, 1, 1, 5'd8, 1, 5'd6, 2'b01, 2'b10};
    vecs[6] = '{5'd5, 1, 5'd5, 1, 1, 5'd5, 0, 5'd5, 2'b10, 2'b10};
    vecs[7] = '{5'd1, 1, 5'd2, 1, 1, 5'd3, 1, 5'd4, 2'b00, 2'b00};

    @(negedge clk);
    rand_id();
    cycle(0);
    rand_id();
    cycle(1);
    chk("rst_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("rst_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    chk("rst_fwd_a", 32'(bus.fwd_a_sel_o), 32'd0);
    chk("rst_fwd_b", 32'(bus.fwd_b_sel_o), 32'd0);
    chk("rst_hazard", 32'(bus.hazard_stall_o), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_fwd(0, 0, 0, 0);
      set_id(1, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, 32'h100 + 32'(i), 5'd20, 8'h01);
      cycle(1);
      set_fwd(vecs[i].exw, vecs[i].exrd, vecs[i].wbw, vecs[i].wbrd);
      #1;
      chk($sformatf("vec%0d_fwd_a", i), 32'(bus.fwd_a_sel_o), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_fwd_b", i), 32'(bus.fwd_b_sel_o), 32'(vecs[i].eb));
    end

    // Load-use: lw x7 then add reading x7
    set_fwd(0, 0, 0, 0);
    set_id(1, 5'd2, 1, 5'd0, 0, 32'h0, 5'd7, 8'h0B);
    cycle(1);
    set_id(1, 5'd1, 1, 5'd7, 1, 32'h55, 5'd10, 8'h01);
    #1;
    chk("lu_hazard", 32'(bus.hazard_stall_o), 32'd1);
    cycle(1);
    chk("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("lu_bubble_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    chk("lu_stall_drop", 32'(bus.hazard_stall_o), 32'd0);
    cycle(1);
    chk("lu_add_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("lu_add_rd", 32'(bus.ex_rd_addr_o), 32'd10);
    chk("lu_add_ctrl", 32'(bus.ex_ctrl_o), 32'h01);

    // Flush takes precedence over a load-use hazard
    set_id(1, 5'd2, 1, 5'd0, 0, 32'h0, 5'd7, 8'h0B);
    cycle(1);
    set_id(1, 5'd1, 1, 5'd7, 1, 32'h55, 5'd10, 8'h01);
    bus.flush_i = 1'b1;
    #1;
    chk("fl_hazard", 32'(bus.hazard_stall_o), 32'd0);
    cycle(1);
    chk("fl_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("fl_ctrl", 32'(bus.ex_ctrl_o), 32'd0);
    chk("fl_rd", 32'(bus.ex_rd_addr_o), 32'd0);
    bus.flush_i = 1'b0;

    // Memory freeze holds EX across changing ID inputs and a flush request
    set_id(1, 5'd3, 0, 5'd4, 0, 32'hDEADBEEF, 5'd12, 8'h11);
    cycle(1);
    for (int i = 0; i < 3; i++) begin
      rand_id();
      bus.mem_stall_i = 1'b1;
      bus.flush_i = 1'b1;
      cycle(1);
      chk("frz_data", bus.ex_rs1_data_o, 32'hDEADBEEF);
      chk("frz_valid", 32'(bus.ex_valid_o), 32'd1);
      chk("frz_rd", 32'(bus.ex_rd_addr_o), 32'd12);
      chk("frz_ctrl", 32'(bus.ex_ctrl_o), 32'h11);
    end
    bus.mem_stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_id(1, 5'd0, 0, 5'd0, 0, 32'h12345678, 5'd13, 8'h01);
    cycle(1);
    chk("resume_data", bus.ex_rs1_data_o, 32'h12345678);
    chk("resume_rd", 32'(bus.ex_rd_addr_o), 32'd13);

    for (int i = 0; i < 600; i++) begin
      rand_id();
      if ($urandom_range(0, 2) == 0) bus.id_ctrl_i[1] = 1'b1;
      rst_n = ($urandom_range(0, 49) != 0);
      bus.mem_stall_i = ($urandom_range(0, 7) == 0);
      bus.flush_i = ($urandom_range(0, 7) == 0);
      cycle(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32 core, fused with the EX-stage forwarding-select generator and load-use hazard detector.
- Captures decoded operands and control from ID and presents them to EX.
- Drives the 2-bit selects of the two 4:1 32-bit operand muxes in EX.
- Raises a stall request to the PC and IF/ID registers on a load-use hazard.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- CTRL_W, 8, packed EX/MEM/WB control bundle width (bit map in package)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-low reset
- mem_stall_i  in  1  global freeze (cache/memory miss); hold all state
- flush_i  in  1  squash the instruction currently in ID (taken branch/jump)
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_addr_i  in  REG_AW  source register 1 address
- id_rs2_addr_i  in  REG_AW  source register 2 address
- id_uses_rs1_i  in  1  instruction reads rs1
- id_uses_rs2_i  in  1  instruction reads rs2
- id_rs1_data_i  in  DATA_W  register-file read data 1 (write-through already applied)
- id_rs2_data_i  in  DATA_W  register-file read data 2
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rd_addr_i  in  REG_AW  destination register
- id_ctrl_i  in  CTRL_W  control bundle
- exmem_reg_write_i  in  1  EX/MEM instruction writes rd
- exmem_rd_i  in  REG_AW  EX/MEM rd
- memwb_reg_write_i  in  1  MEM/WB instruction writes rd
- memwb_rd_i  in  REG_AW  MEM/WB rd
- ex_valid_o  out  1  EX holds a real instruction
- ex_rs1_addr_o, ex_rs2_addr_o  out  REG_AW  registered source addresses
- ex_rs1_data_o, ex_rs2_data_o  out  DATA_W  registered operands (mux select 00 input)
- ex_imm_o  out  DATA_W  registered immediate
- ex_rd_addr_o  out  REG_AW  registered rd
- ex_ctrl_o  out  CTRL_W  registered control; all zero when ex_valid_o=0
- fwd_a_sel_o, fwd_b_sel_o  out  2  operand mux selects
- hazard_stall_o  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_i=0 at posedge): all registered outputs cleared to 0, including ex_valid_o and ex_ctrl_o. Combinational outputs then evaluate to fwd sel 00 and hazard_stall_o 0.
- Register update priority at each posedge:
  1. Reset.
  2. mem_stall_i=1: hold every register unchanged. flush_i and the hazard are ignored for update.
  3. flush_i=1: load a bubble (valid 0, ctrl 0; data/addr fields don't-care but cleared to 0).
  4. hazard_stall_o=1: load a bubble.
  5. Otherwise: load all ID fields, with ex_valid_o = id_valid_i.
- id_valid_i=0 always loads ctrl as 0.
- Latency: ID fields appear on ex_* one cycle after capture.
- hazard_stall_o is combinational. It is 1 when all of the following hold:
  - id_valid_i, ex_valid_o, ex_ctrl_o[MEM_READ] and ~flush_i are all 1;
  - ex_rd_addr_o != 0;
  - id_uses_rs1_i with id_rs1_addr_i == ex_rd_addr_o, or id_uses_rs2_i with id_rs2_addr_i == ex_rd_addr_o.
- hazard_stall_o is asserted regardless of mem_stall_i; it is harmless because upstream is frozen anyway. Exactly one bubble is inserted per load-use pair. The next cycle the load is in MEM and the dependency resolves via MEM/WB forwarding.
- Forwarding selects are combinational from registered EX addresses. For operand A (B is identical with rs2/uses_rs2):
  - 2'b10 (EX/MEM result) if ex_valid_o, uses_rs1 registered, exmem_reg_write_i, exmem_rd_i != 0 and exmem_rd_i == ex_rs1_addr_o.
  - else 2'b01 (MEM/WB write-back data) under the same conditions on memwb_*.
  - else 2'b00 (ex_rs1_data_o).
- 2'b11 is never driven. The mux input 11 is reserved.
- The uses_rs flags are registered alongside the addresses (internal). They are cleared in bubbles, so a bubble always yields sel 00.
- Register x0 is never a forwarding or hazard source.
- No arithmetic on data paths; widths pass through unchanged.

Decomposition:
- Package pipe_pkg holds:
  - CTRL bit indices: REG_WRITE=0, MEM_READ=1, MEM_WRITE=2, MEM_TO_REG=3, ALU_SRC=4, ALU_OP=7:5;
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_RSVD=2'b11.
- One sub-module, fwd_sel_unit: pure combinational select for a single operand, instantiated twice (A and B).

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with random ID inputs -> ex_valid_o=0, ex_ctrl_o=0, both sel 00, hazard_stall_o=0.
- EX/MEM priority: EX holds rs1=5, uses_rs1=1; exmem rd=5 with write=1; memwb rd=5 with write=1 -> fwd_a_sel_o=10. Drop exmem write -> 01. Set rd=0 on both -> 00.
- Load-use: EX holds lw rd=7 (MEM_READ=1); ID holds add with rs2=7 and uses_rs2=1 -> hazard_stall_o=1, next cycle ex_valid_o=0 and ex_ctrl_o=0. With ID held, stall drops the following cycle and the add loads.
- Flush vs hazard: same load-use setup with flush_i=1 -> hazard_stall_o=0, bubble loaded.
- Memory freeze: mem_stall_i=1 for 3 cycles with changing ID inputs and flush_i=1 -> all ex_* outputs unchanged, including ex_rs1_data_o=32'hDEADBEEF. They resume on the first cycle mem_stall_i=0.
- Unused operand: lui (uses_rs1=0, rs1 field=3) in EX with exmem rd=3 writing -> fwd_a_sel_o=00.
